// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard interface: instruction fields offered by D, and the
// stall / forwarding decisions returned to the datapath.
//
// Handshake: D presents an instruction with d_valid=1. It is accepted into E
// on the next clk edge only if stall=0 and flush=0 on that edge. While
// stall=1 the D fields must be held steady; a bubble goes into E instead.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2,
  parameter int SEL_W  = 2
);
  logic              flush;
  logic              d_valid;
  logic [ADDR_W-1:0] d_rs;
  logic [ADDR_W-1:0] d_rt;
  logic [TNEW_W-1:0] d_rs_use;
  logic [TNEW_W-1:0] d_rt_use;
  logic              d_wr;
  logic [ADDR_W-1:0] d_wa;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_mtc0_epc;
  logic              d_eret;
  logic              d_mdu_use;
  logic              d_mdu_start;
  logic              d_mdu_div;
  logic              stall;
  logic [SEL_W-1:0]  fwd_d_rs;
  logic [SEL_W-1:0]  fwd_d_rt;
  logic [SEL_W-1:0]  fwd_e_rs;
  logic [SEL_W-1:0]  fwd_e_rt;
  logic [SEL_W-1:0]  fwd_m_rt;
  logic              mdu_busy;

  modport master (
    output flush, d_valid, d_rs, d_rt, d_rs_use, d_rt_use, d_wr, d_wa, d_tnew,
           d_mtc0_epc, d_eret, d_mdu_use, d_mdu_start, d_mdu_div,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, mdu_busy
  );

  modport slave (
    input  flush, d_valid, d_rs, d_rt, d_rs_use, d_rt_use, d_wr, d_wa, d_tnew,
           d_mtc0_epc, d_eret, d_mdu_use, d_mdu_start, d_mdu_div,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, mdu_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order MIPS pipeline.
// Keeps a shift-register scoreboard of in-flight instructions past D
// (entry 0 = E, 1 = M, ..., STAGES-1 = W) and an MDU latency counter.
// Forwarding select k means "take the result of entry k-1"; 0 = no forward.
module hazard_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int STAGES  = 3,
  parameter int TNEW_W  = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10,
  parameter int SEL_W   = $clog2(STAGES + 1)
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave hz
);
  localparam int CNT_W = $clog2(DIV_CYC + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] wa;
    logic [TNEW_W-1:0] tnew;
    logic              epc;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic [SEL_W-1:0]  sel;
    logic [TNEW_W-1:0] tnew;
  } match_t;

  entry_t [STAGES-1:0] ent;
  entry_t [STAGES-1:0] ent_nxt;
  logic [CNT_W-1:0]    cnt;

  match_t m_d_rs, m_d_rt, m_e_rs, m_e_rt, m_m_rt;
  logic   any_epc;
  logic   stall_int;

  // Youngest writer of r among entries lo..STAGES-1; scanning from the old
  // end lets the lowest-index hit overwrite older ones. $0 never matches.
  function automatic match_t youngest(input entry_t [STAGES-1:0] e,
                                      input logic [ADDR_W-1:0] r,
                                      input int lo);
    match_t m;
    m = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (i >= lo && e[i].valid && e[i].wa == r && r != '0) begin
        m.hit  = 1'b1;
        m.sel  = SEL_W'(i + 1);
        m.tnew = e[i].tnew;
      end
    end
    return m;
  endfunction

  // A match may only be forwarded once its result exists (tnew == 0).
  function automatic logic [SEL_W-1:0] fwd_of(input match_t m);
    return (m.hit && m.tnew == '0) ? m.sel : '0;
  endfunction

  // Dependency search, stall decision and forwarding selects.
  always_comb begin
    m_d_rs  = youngest(ent, hz.d_rs, 0);
    m_d_rt  = youngest(ent, hz.d_rt, 0);
    m_e_rs  = youngest(ent, ent[0].rs, 1);
    m_e_rt  = youngest(ent, ent[0].rt, 1);
    m_m_rt  = youngest(ent, ent[1].rt, 2);
    any_epc = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      any_epc = any_epc | ent[i].epc;
    end
    stall_int = hz.d_valid & (
                  (m_d_rs.hit && (m_d_rs.tnew > hz.d_rs_use)) ||
                  (m_d_rt.hit && (m_d_rt.tnew > hz.d_rt_use)) ||
                  (hz.d_eret && any_epc) ||
                  (hz.d_mdu_use && (cnt != '0)));
  end

  assign hz.stall    = stall_int;
  assign hz.fwd_d_rs = fwd_of(m_d_rs);
  assign hz.fwd_d_rt = fwd_of(m_d_rt);
  assign hz.fwd_e_rs = fwd_of(m_e_rs);
  assign hz.fwd_e_rt = fwd_of(m_e_rt);
  assign hz.fwd_m_rt = fwd_of(m_m_rt);
  assign hz.mdu_busy = (cnt != '0);

  // Next scoreboard contents: shift with saturating tnew decrement, and
  // load entry 0 from D or with a bubble while stalled. Reader fields of a
  // non-instruction are zeroed so it can never select a forwarding source.
  always_comb begin
    ent_nxt = '0;
    for (int i = 1; i < STAGES; i++) begin
      ent_nxt[i]      = ent[i-1];
      ent_nxt[i].tnew = (ent[i-1].tnew == '0) ? '0 : ent[i-1].tnew - TNEW_W'(1);
    end
    if (!stall_int && hz.d_valid) begin
      ent_nxt[0].valid = hz.d_wr && (hz.d_wa != '0);
      ent_nxt[0].wa    = hz.d_wa;
      ent_nxt[0].tnew  = hz.d_tnew;
      ent_nxt[0].epc   = hz.d_mtc0_epc;
      ent_nxt[0].rs    = hz.d_rs;
      ent_nxt[0].rt    = hz.d_rt;
    end
  end

  // Scoreboard register; flush wipes every entry including epc flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent <= '0;
    end else if (hz.flush) begin
      ent <= '0;
    end else begin
      ent <= ent_nxt;
    end
  end

  // MDU latency counter; a flush lets an already-started operation finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (hz.d_valid && hz.d_mdu_start && !stall_int && !hz.flush) begin
      cnt <= hz.d_mdu_div ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table for the
// pipeline hazard scenarios, hand sequences for MDU timing and reset.
module tb_hazard_scoreboard;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  hazard_scoreboard_if #(.ADDR_W(5), .TNEW_W(2), .SEL_W(2)) hz ();

  hazard_scoreboard #(
    .ADDR_W(5), .STAGES(3), .TNEW_W(2), .MUL_CYC(5), .DIV_CYC(10), .SEL_W(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       flush;
    logic       valid;
    logic [4:0] rs;
    logic [1:0] rs_use;
    logic [4:0] rt;
    logic [1:0] rt_use;
    logic       wr;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       epc;
    logic       eret;
    logic       stall;
    logic [1:0] f_drs;
    logic [1:0] f_drt;
    logic [1:0] f_ers;
    logic [1:0] f_ert;
    logic [1:0] f_mrt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic v,
                              input logic [4:0] rs, input logic [1:0] ru,
                              input logic [4:0] rt, input logic [1:0] tu,
                              input logic wr, input logic [4:0] wa,
                              input logic [1:0] tn, input logic epc,
                              input logic eret, input logic st,
                              input logic [1:0] fdrs, input logic [1:0] fdrt,
                              input logic [1:0] fers, input logic [1:0] fert,
                              input logic [1:0] fmrt);
    vec_t r;
    r.flush = fl;  r.valid = v;   r.rs = rs;     r.rs_use = ru;
    r.rt = rt;     r.rt_use = tu; r.wr = wr;     r.wa = wa;
    r.tnew = tn;   r.epc = epc;   r.eret = eret; r.stall = st;
    r.f_drs = fdrs; r.f_drt = fdrt; r.f_ers = fers; r.f_ert = fert;
    r.f_mrt = fmrt;
    return r;
  endfunction

  function automatic vec_t nop(input logic [1:0] fers, input logic [1:0] fert,
                               input logic [1:0] fmrt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fers, fert, fmrt);
  endfunction

  // Scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic st, input logic [1:0] fdrs,
                         input logic [1:0] fdrt, input logic [1:0] fers,
                         input logic [1:0] fert, input logic [1:0] fmrt,
                         input logic busy);
    chk({nm, " stall"},    hz.stall,    st);
    chk({nm, " fwd_d_rs"}, hz.fwd_d_rs, fdrs);
    chk({nm, " fwd_d_rt"}, hz.fwd_d_rt, fdrt);
    chk({nm, " fwd_e_rs"}, hz.fwd_e_rs, fers);
    chk({nm, " fwd_e_rt"}, hz.fwd_e_rt, fert);
    chk({nm, " fwd_m_rt"}, hz.fwd_m_rt, fmrt);
    chk({nm, " mdu_busy"}, hz.mdu_busy, busy);
  endtask

  // Driver tasks
  task automatic clear_d();
    hz.flush = 0; hz.d_valid = 0; hz.d_rs = 0; hz.d_rt = 0;
    hz.d_rs_use = 0; hz.d_rt_use = 0; hz.d_wr = 0; hz.d_wa = 0; hz.d_tnew = 0;
    hz.d_mtc0_epc = 0; hz.d_eret = 0; hz.d_mdu_use = 0; hz.d_mdu_start = 0;
    hz.d_mdu_div = 0;
  endtask

  task automatic apply(input vec_t v);
    clear_d();
    hz.flush = v.flush; hz.d_valid = v.valid; hz.d_rs = v.rs; hz.d_rs_use = v.rs_use;
    hz.d_rt = v.rt; hz.d_rt_use = v.rt_use; hz.d_wr = v.wr; hz.d_wa = v.wa;
    hz.d_tnew = v.tnew; hz.d_mtc0_epc = v.epc; hz.d_eret = v.eret;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    clear_d();
    for (int i = 0; i < 4; i++) step();
  endtask

  // Start mult/div, then hold mflo in D and measure stall/busy cycles.
  task automatic mdu_run(input string nm, input logic is_div, input int exp_n);
    int n_stall;
    int n_busy;
    int guard;
    clear_d();
    hz.d_valid = 1; hz.d_mdu_use = 1; hz.d_mdu_start = 1; hz.d_mdu_div = is_div;
    #2;
    chk({nm, " issue stall"}, hz.stall, 0);
    step();
    clear_d();
    hz.d_valid = 1; hz.d_mdu_use = 1; hz.d_wr = 1; hz.d_wa = 3; hz.d_tnew = 1;
    #2;
    n_stall = 0; n_busy = 0; guard = 0;
    while (hz.stall && guard < 40) begin
      n_stall++;
      if (hz.mdu_busy) n_busy++;
      @(posedge clk);
      #3;
      guard++;
    end
    chk({nm, " stall cycles"}, n_stall, exp_n);
    chk({nm, " busy cycles"}, n_busy, exp_n);
    chk({nm, " stall after"}, hz.stall, 0);
    chk({nm, " busy after"}, hz.mdu_busy, 0);
    step();
    drain();
  endtask

  // Main test
  initial begin
    int n;
    total = 0;
    bad   = 0;
    clear_d();
    reset = 1'b1;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    //        fl v  rs ru rt tu wr wa tn ep er | st dr dt er et mr
    vecs.push_back(nop(0, 0, 0));
    // load-use: lw $8 then add $10,$8,$9
    vecs.push_back(mk(0, 1, 4, 1, 0, 0, 1, 8, 2, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8, 1, 9, 1, 1, 10, 1, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8, 1, 9, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(3, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // branch compare: addu $9 then beq $9,$0
    vecs.push_back(mk(0, 1, 2, 1, 3, 1, 1, 9, 1, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0));
    vecs.push_back(nop(3, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // youngest wins: ori $5, addu $5, sw $5
    vecs.push_back(mk(0, 1, 6, 1, 0, 0, 1, 5, 1, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 7, 1, 11, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 12, 1, 5, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 2, 0));
    vecs.push_back(nop(0, 0, 3));
    vecs.push_back(nop(0, 0, 0));
    // zero register: lw $0 then add $10,$0,$0
    vecs.push_back(mk(0, 1, 4, 1, 0, 0, 1, 0, 2, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 10, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // mtc0 EPC then eret: three stalled cycles
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0));
    // flush with lw $8 in E, then dependent add
    vecs.push_back(mk(0, 1, 4, 1, 0, 0, 1, 8, 2, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8, 0, 8, 0, 1, 10, 1, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    // flush overrides issue of lw $7 in D
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 7, 2, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));
    vecs.push_back(nop(0, 0, 0));

    foreach (vecs[k]) begin
      apply(vecs[k]);
      #2;
      chk_all($sformatf("v%0d", k), vecs[k].stall, vecs[k].f_drs, vecs[k].f_drt,
              vecs[k].f_ers, vecs[k].f_ert, vecs[k].f_mrt, 0);
      step();
    end
    drain();

    // MDU latency
    mdu_run("div", 1'b1, 10);
    mdu_run("mult", 1'b0, 5);

    // start blocked by flush: counter must stay idle
    clear_d();
    hz.d_valid = 1; hz.d_mdu_use = 1; hz.d_mdu_start = 1; hz.flush = 1;
    step();
    clear_d();
    #2;
    chk("flushed start busy", hz.mdu_busy, 0);
    step();

    // flush does not cancel a started mult
    hz.d_valid = 1; hz.d_mdu_use = 1; hz.d_mdu_start = 1;
    step();
    clear_d();
    hz.flush = 1;
    #2;
    chk("flush busy before", hz.mdu_busy, 1);
    step();
    clear_d();
    #2;
    n = 0;
    while (hz.mdu_busy && n < 20) begin
      n++;
      step();
      #2;
    end
    chk("flush busy remaining", n, 4);
    drain();

    // async reset mid-div with mflo waiting in D
    hz.d_valid = 1; hz.d_mdu_use = 1; hz.d_mdu_start = 1; hz.d_mdu_div = 1;
    step();
    clear_d();
    hz.d_valid = 1; hz.d_mdu_use = 1; hz.d_wr = 1; hz.d_wa = 3; hz.d_tnew = 1;
    step();
    step();
    #1;
    chk("mid-div busy", hz.mdu_busy, 1);
    chk("mid-div stall", hz.stall, 1);
    reset = 1'b1;
    #1;
    chk_all("async reset", 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    step();
    #1;
    chk("after reset busy", hz.mdu_busy, 0);
    chk("after reset stall", hz.stall, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
